// File: rtl/fp16_align_stage_if.sv
// Handshake bundle for the FP16 alignment front end.
// slave is the stage's view; master is the driver/consumer view.
interface fp16_align_stage_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [10:0] big_mant;
    logic [10:0] small_mant;
    logic [4:0]  shift_ctrl;
    logic [4:0]  exp_big;
    logic        sign_big;
    logic        sign_small;
    logic        swapped;
    logic        eff_sub;
    logic        any_nan;
    logic        any_inf;

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid,
        output big_mant, small_mant, shift_ctrl, exp_big,
        output sign_big, sign_small, swapped, eff_sub,
        output any_nan, any_inf
    );

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid,
        input  big_mant, small_mant, shift_ctrl, exp_big,
        input  sign_big, sign_small, swapped, eff_sub,
        input  any_nan, any_inf
    );
endinterface

// File: rtl/fp16_align_stage.sv
// FP16 add/sub operand alignment: unpack, order by magnitude,
// and produce a saturated shift control for the mantissa shifter.
module fp16_align_stage (
    input logic clk,
    input logic reset,
    fp16_align_stage_if.slave io
);
    typedef struct packed {
        logic        sa;
        logic        sb;
        logic [4:0]  ea;
        logic [4:0]  eb;
        logic [10:0] ma;
        logic [10:0] mb;
        logic        na;
        logic        nb;
        logic        ia;
        logic        ib;
    } unpk_t;

    typedef struct packed {
        logic [10:0] big_mant;
        logic [10:0] small_mant;
        logic [4:0]  shift_ctrl;
        logic [4:0]  exp_big;
        logic        sign_big;
        logic        sign_small;
        logic        swapped;
        logic        eff_sub;
        logic        any_nan;
        logic        any_inf;
    } algn_t;

    logic  s1_v, s2_v;
    logic  s1_adv, s2_adv;
    unpk_t s1_d, s1_q;
    algn_t s2_d, s2_q;

    assign s2_adv      = !s2_v || io.out_ready;
    assign s1_adv      = !s1_v || s2_adv;
    assign io.in_ready = s1_adv;

    logic [4:0] raw_ea, raw_eb;
    logic       hid_a, hid_b;

    assign raw_ea = io.a[14:10];
    assign raw_eb = io.b[14:10];
    assign hid_a  = |raw_ea;
    assign hid_b  = |raw_eb;

    // Subnormals share exponent 1 with the smallest normals.
    always_comb begin
        s1_d    = '0;
        s1_d.sa = io.a[15];
        s1_d.sb = io.b[15];
        s1_d.ea = hid_a ? raw_ea : 5'd1;
        s1_d.eb = hid_b ? raw_eb : 5'd1;
        s1_d.ma = {hid_a, io.a[9:0]};
        s1_d.mb = {hid_b, io.b[9:0]};
        s1_d.na = (&raw_ea) && (|io.a[9:0]);
        s1_d.nb = (&raw_eb) && (|io.b[9:0]);
        s1_d.ia = (&raw_ea) && !(|io.a[9:0]);
        s1_d.ib = (&raw_eb) && !(|io.b[9:0]);
    end

    logic       b_gt;
    logic [4:0] e_small;
    logic [4:0] diff;

    assign b_gt = {s1_q.eb, s1_q.mb} > {s1_q.ea, s1_q.ma};

    always_comb begin
        s2_d            = '0;
        s2_d.swapped    = b_gt;
        s2_d.big_mant   = b_gt ? s1_q.mb : s1_q.ma;
        s2_d.small_mant = b_gt ? s1_q.ma : s1_q.mb;
        s2_d.exp_big    = b_gt ? s1_q.eb : s1_q.ea;
        s2_d.sign_big   = b_gt ? s1_q.sb : s1_q.sa;
        s2_d.sign_small = b_gt ? s1_q.sa : s1_q.sb;
        s2_d.eff_sub    = s1_q.sa ^ s1_q.sb;
        s2_d.any_nan    = s1_q.na | s1_q.nb;
        s2_d.any_inf    = s1_q.ia | s1_q.ib;
        e_small         = b_gt ? s1_q.ea : s1_q.eb;
        diff            = s2_d.exp_big - e_small;
        // 16 is the canonical full-clear code for the shifter.
        s2_d.shift_ctrl = diff[4] ? 5'd16 : diff;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_v <= 1'b0;
            s1_q <= '0;
        end else if (s1_adv) begin
            s1_v <= io.in_valid;
            if (io.in_valid)
                s1_q <= s1_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s2_v <= 1'b0;
            s2_q <= '0;
        end else if (s2_adv) begin
            s2_v <= s1_v;
            if (s1_v)
                s2_q <= s2_d;
        end
    end

    assign io.out_valid  = s2_v;
    assign io.big_mant   = s2_q.big_mant;
    assign io.small_mant = s2_q.small_mant;
    assign io.shift_ctrl = s2_q.shift_ctrl;
    assign io.exp_big    = s2_q.exp_big;
    assign io.sign_big   = s2_q.sign_big;
    assign io.sign_small = s2_q.sign_small;
    assign io.swapped    = s2_q.swapped;
    assign io.eff_sub    = s2_q.eff_sub;
    assign io.any_nan    = s2_q.any_nan;
    assign io.any_inf    = s2_q.any_inf;
endmodule

// File: tb/tb_fp16_align_stage.sv
// Directed vector bench for fp16_align_stage: latency, streaming,
// backpressure and asynchronous reset behaviour.
module tb_fp16_align_stage;
    logic clk = 1'b0;
    logic reset = 1'b1;

    fp16_align_stage_if io();

    fp16_align_stage dut (
        .clk   (clk),
        .reset (reset),
        .io    (io)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [37:0] exp;
    } vec_t;

    vec_t vecs[13];
    int   total  = 0;
    int   passed = 0;

    function automatic logic [37:0] mk(
        input logic [10:0] bm, input logic [10:0] sm,
        input logic [4:0] sh, input logic [4:0] eb,
        input logic sb, input logic ss, input logic sw,
        input logic es, input logic nn, input logic ii);
        return {bm, sm, sh, eb, sb, ss, sw, es, nn, ii};
    endfunction

    function automatic logic [37:0] outs();
        return {io.big_mant, io.small_mant, io.shift_ctrl,
                io.exp_big, io.sign_big, io.sign_small,
                io.swapped, io.eff_sub, io.any_nan, io.any_inf};
    endfunction

    task automatic chk(input string nm, input logic [37:0] act,
                       input logic [37:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s actual=%h required=%h", nm, act, req);
    endtask

    task automatic drive(input logic v, input logic [15:0] a,
                         input logic [15:0] b);
        io.in_valid = v;
        io.a        = a;
        io.b        = b;
    endtask

    // One pair through an empty pipe with out_ready high.
    task automatic run_one(input int i);
        @(negedge clk);
        drive(1'b1, vecs[i].a, vecs[i].b);
        #1 chk($sformatf("v%0d in_ready", i), 38'(io.in_ready), 38'd1);
        @(negedge clk);
        drive(1'b0, 16'h0, 16'h0);
        #1 chk($sformatf("v%0d lat1", i), 38'(io.out_valid), 38'd0);
        @(negedge clk);
        #1 chk($sformatf("v%0d lat2", i), 38'(io.out_valid), 38'd1);
        chk($sformatf("v%0d data", i), outs(), vecs[i].exp);
    endtask

    initial begin
        vecs[0]  = '{16'h3C00, 16'h3800, mk(11'h400, 11'h400, 5'd1,  5'd15, 0, 0, 0, 0, 0, 0)};
        vecs[1]  = '{16'h3800, 16'hBC00, mk(11'h400, 11'h400, 5'd1,  5'd15, 1, 0, 1, 1, 0, 0)};
        vecs[2]  = '{16'h7BFF, 16'h0001, mk(11'h7FF, 11'h001, 5'd16, 5'd30, 0, 0, 0, 0, 0, 0)};
        vecs[3]  = '{16'h7E00, 16'h7C00, mk(11'h600, 11'h400, 5'd0,  5'd31, 0, 0, 0, 0, 1, 1)};
        vecs[4]  = '{16'h0001, 16'h7BFF, mk(11'h7FF, 11'h001, 5'd16, 5'd30, 0, 0, 1, 0, 0, 0)};
        vecs[5]  = '{16'h4000, 16'h4000, mk(11'h400, 11'h400, 5'd0,  5'd16, 0, 0, 0, 0, 0, 0)};
        vecs[6]  = '{16'h4000, 16'hC000, mk(11'h400, 11'h400, 5'd0,  5'd16, 0, 1, 0, 1, 0, 0)};
        vecs[7]  = '{16'h4000, 16'h0400, mk(11'h400, 11'h400, 5'd15, 5'd16, 0, 0, 0, 0, 0, 0)};
        vecs[8]  = '{16'h4400, 16'h0400, mk(11'h400, 11'h400, 5'd16, 5'd17, 0, 0, 0, 0, 0, 0)};
        vecs[9]  = '{16'h0000, 16'h8000, mk(11'h000, 11'h000, 5'd0,  5'd1,  0, 1, 0, 1, 0, 0)};
        vecs[10] = '{16'h8000, 16'h0001, mk(11'h001, 11'h000, 5'd0,  5'd1,  0, 1, 1, 1, 0, 0)};
        vecs[11] = '{16'hFC00, 16'h3C00, mk(11'h400, 11'h400, 5'd16, 5'd31, 1, 0, 0, 1, 0, 1)};
        vecs[12] = '{16'h0400, 16'h03FF, mk(11'h400, 11'h3FF, 5'd0,  5'd1,  0, 0, 0, 0, 0, 0)};

        drive(1'b0, 16'h0, 16'h0);
        io.out_ready = 1'b1;

        // Power-on reset
        repeat (2) @(negedge clk);
        #1 chk("rst out_valid", 38'(io.out_valid), 38'd0);
        chk("rst data", outs(), 38'd0);
        @(negedge clk);
        reset = 1'b0;
        #1 chk("rst in_ready", 38'(io.in_ready), 38'd1);

        // Latency and data per vector
        for (int i = 0; i < 13; i++) run_one(i);

        // Back-to-back streaming, one pair per cycle
        begin
            int recv = 0;
            for (int c = 0; c < 17; c++) begin
                @(negedge clk);
                if (c < 13) drive(1'b1, vecs[c].a, vecs[c].b);
                else        drive(1'b0, 16'h0, 16'h0);
                #1;
                chk($sformatf("stream vld c%0d", c), 38'(io.out_valid),
                    38'(c >= 2 && c < 15));
                if (io.out_valid && recv < 13) begin
                    chk($sformatf("stream data %0d", recv), outs(),
                        vecs[recv].exp);
                    recv++;
                end
            end
            chk("stream count", 38'(recv), 38'd13);
        end

        // Backpressure: 4 pairs, out_ready low for 4 cycles
        begin
            int          sent = 0;
            int          recv = 0;
            logic        fire_in;
            logic        prev_stall = 1'b0;
            logic [37:0] prev_out = '0;
            for (int c = 0; c < 14; c++) begin
                @(negedge clk);
                io.out_ready = (c >= 4);
                if (sent < 4) drive(1'b1, vecs[sent].a, vecs[sent].b);
                else          drive(1'b0, 16'h0, 16'h0);
                #1;
                fire_in = io.in_valid && io.in_ready;
                if (c == 2 || c == 3) begin
                    chk($sformatf("bp in_ready c%0d", c),
                        38'(io.in_ready), 38'd0);
                    chk($sformatf("bp sent c%0d", c), 38'(sent), 38'd2);
                end
                if (prev_stall)
                    chk($sformatf("bp hold c%0d", c),
                        {io.out_valid, outs()}, {1'b1, prev_out});
                if (io.out_valid && io.out_ready) begin
                    if (recv < 4)
                        chk($sformatf("bp data %0d", recv), outs(),
                            vecs[recv].exp);
                    recv++;
                end
                prev_stall = io.out_valid && !io.out_ready;
                prev_out   = outs();
                @(posedge clk);
                if (fire_in) sent++;
            end
            chk("bp sent", 38'(sent), 38'd4);
            chk("bp recv", 38'(recv), 38'd4);
        end

        // Reset with both stages full
        @(negedge clk);
        io.out_ready = 1'b0;
        drive(1'b1, vecs[0].a, vecs[0].b);
        @(negedge clk);
        drive(1'b1, vecs[1].a, vecs[1].b);
        @(negedge clk);
        drive(1'b0, 16'h0, 16'h0);
        #1 chk("mid full vld", 38'(io.out_valid), 38'd1);
        chk("mid full rdy", 38'(io.in_ready), 38'd0);
        #2 reset = 1'b1;
        #1 chk("mid rst vld", 38'(io.out_valid), 38'd0);
        chk("mid rst data", outs(), 38'd0);
        @(negedge clk);
        reset = 1'b0;
        io.out_ready = 1'b1;
        #1 chk("post rst rdy", 38'(io.in_ready), 38'd1);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            #1 chk($sformatf("post rst stale %0d", c),
                   38'(io.out_valid), 38'd0);
        end
        run_one(2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
